// File: rtl/ast_rr_packet_arbiter_pkg.sv
// Shared types and sizing for the packet round-robin arbiter.
// Holds the stream geometry, the beat payload and the FSM state enum.
package ast_rr_packet_arbiter_pkg;

    localparam int unsigned DATA_WIDTH    = 64;
    localparam int unsigned CHANNEL_W     = 10;
    localparam int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned TX_DIR        = 4;
    localparam int unsigned DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR);

    typedef logic [DATA_WIDTH-1:0]    data_t;
    typedef logic [CHANNEL_W-1:0]     channel_t;
    typedef logic [EMPTY_WIDTH-1:0]   empty_t;
    typedef logic [DIR_SEL_WIDTH-1:0] dir_sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // One Avalon-ST beat as carried through the output register.
    typedef struct packed {
        data_t    data;
        logic     sop;
        logic     eop;
        empty_t   empty;
        channel_t channel;
    } ast_beat_t;

endpackage

// File: rtl/ast_rr_packet_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after last_grant+1,
// scanning upward with wrap-around.
module rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = (N == 1) ? 1 : $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         grant_valid
);

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        for (int unsigned k = N; k > 0; k--) begin
            idx = 32'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[W'(idx)]) begin
                grant = W'(idx);
            end
        end
    end

    assign grant_valid = |req;

endmodule

// File: rtl/ast_rr_packet_arbiter.sv
// Packet-granular round-robin merge of TX_DIR Avalon-ST sources into one
// registered output stream tagged with the source index.
module ast_rr_packet_arbiter
    import ast_rr_packet_arbiter_pkg::*;
(
    input  logic                                clk_i,
    input  logic                                srst_i,
    input  logic [TX_DIR-1:0][DATA_WIDTH-1:0]   ast_data_i,
    input  logic [TX_DIR-1:0]                   ast_startofpacket_i,
    input  logic [TX_DIR-1:0]                   ast_endofpacket_i,
    input  logic [TX_DIR-1:0]                   ast_valid_i,
    input  logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]  ast_empty_i,
    input  logic [TX_DIR-1:0][CHANNEL_W-1:0]    ast_channel_i,
    output logic [TX_DIR-1:0]                   ast_ready_o,
    output logic [DATA_WIDTH-1:0]               ast_data_o,
    output logic                                ast_startofpacket_o,
    output logic                                ast_endofpacket_o,
    output logic                                ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]              ast_empty_o,
    output logic [CHANNEL_W-1:0]                ast_channel_o,
    output logic [DIR_SEL_WIDTH-1:0]            dir_o,
    input  logic                                ast_ready_i
);

    arb_state_t  state_q;
    arb_state_t  state_d;
    dir_sel_t    grant_q;
    dir_sel_t    last_grant_q;
    dir_sel_t    arb_grant;
    dir_sel_t    dir_q;
    logic        arb_valid;
    logic [TX_DIR-1:0] req;
    logic        take_c;
    logic        accept;
    ast_beat_t   in_beat;
    ast_beat_t   out_q;
    logic        out_valid_q;

    assign req = ast_valid_i & ast_startofpacket_i;

    rr_arbiter #(
        .N (TX_DIR),
        .W (DIR_SEL_WIDTH)
    ) u_rr_arbiter (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign take_c = ~out_valid_q | ast_ready_i;
    assign accept = (state_q == ST_BUSY) & ast_valid_i[grant_q] & take_c;

    assign in_beat = '{
        data:    ast_data_i[grant_q],
        sop:     ast_startofpacket_i[grant_q],
        eop:     ast_endofpacket_i[grant_q],
        empty:   ast_empty_i[grant_q],
        channel: ast_channel_i[grant_q]
    };

    always_comb begin
        ast_ready_o = '0;
        if (state_q == ST_BUSY) begin
            ast_ready_o[grant_q] = take_c;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_valid) state_d = ST_BUSY;
            ST_BUSY: if (accept && ast_endofpacket_i[grant_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant is latched only on the IDLE arbitration cycle and held to eop.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= DIR_SEL_WIDTH'(TX_DIR - 1);
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            dir_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && arb_valid) begin
                grant_q      <= arb_grant;
                last_grant_q <= arb_grant;
            end
            if (accept) begin
                out_q       <= in_beat;
                out_valid_q <= 1'b1;
                dir_q       <= grant_q;
            end else if (ast_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign ast_data_o          = out_q.data;
    assign ast_startofpacket_o = out_q.sop;
    assign ast_endofpacket_o   = out_q.eop;
    assign ast_empty_o         = out_q.empty;
    assign ast_channel_o       = out_q.channel;
    assign ast_valid_o         = out_valid_q;
    assign dir_o               = dir_q;

endmodule

// File: tb/tb_ast_rr_packet_arbiter.sv
// Self-checking bench for ast_rr_packet_arbiter: arbitration table, directed
// multi-cycle sequences and randomized traffic against a packet-level model.
module tb_ast_rr_packet_arbiter;
    import ast_rr_packet_arbiter_pkg::*;

    typedef struct {
        logic [63:0]  data;
        logic         sop;
        logic         eop;
        logic [2:0]   empty;
        logic [9:0]   channel;
        int unsigned  dir;
        int unsigned  cyc;
    } tb_beat_t;

    typedef struct {
        int unsigned pre;
        logic [3:0]  mask;
        int unsigned exp_dir;
    } arb_vec_t;

    localparam logic [63:0] STRAY = 64'hDEAD_BEEF_0BAD_F00D;

    logic clk = 1'b0;
    logic srst_i = 1'b1;
    logic [TX_DIR-1:0][DATA_WIDTH-1:0]  ast_data_i = '0;
    logic [TX_DIR-1:0]                  ast_startofpacket_i = '0;
    logic [TX_DIR-1:0]                  ast_endofpacket_i = '0;
    logic [TX_DIR-1:0]                  ast_valid_i = '0;
    logic [TX_DIR-1:0][EMPTY_WIDTH-1:0] ast_empty_i = '0;
    logic [TX_DIR-1:0][CHANNEL_W-1:0]   ast_channel_i = '0;
    logic [TX_DIR-1:0]                  ast_ready_o;
    logic [DATA_WIDTH-1:0]              ast_data_o;
    logic                               ast_startofpacket_o;
    logic                               ast_endofpacket_o;
    logic                               ast_valid_o;
    logic [EMPTY_WIDTH-1:0]             ast_empty_o;
    logic [CHANNEL_W-1:0]               ast_channel_o;
    logic [DIR_SEL_WIDTH-1:0]           dir_o;
    logic                               ast_ready_i = 1'b1;

    ast_rr_packet_arbiter dut (
        .clk_i               (clk),
        .srst_i              (srst_i),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .dir_o               (dir_o),
        .ast_ready_i         (ast_ready_i)
    );

    always #5 clk = ~clk;

    tb_beat_t    src_q[TX_DIR][$];
    tb_beat_t    mdl_q[TX_DIR][$];
    tb_beat_t    log_q[$];
    tb_beat_t    exp_q[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned hold_cnt = 0;
    bit          gap_en = 1'b0;
    int unsigned rdy_mode = 0;
    logic [TX_DIR-1:0] stray_mask = '0;
    bit          stalled = 1'b0;
    logic [127:0] held = '0;
    arb_vec_t    tbl[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o, dir_o});
    endfunction

    function automatic logic [127:0] beat_vec(input tb_beat_t b);
        return 128'({b.data, b.sop, b.eop, b.empty, b.channel, DIR_SEL_WIDTH'(b.dir)});
    endfunction

    function automatic tb_beat_t mk(input logic [63:0] d, input logic s, input logic e,
                                    input logic [2:0] em, input logic [9:0] ch, input int unsigned dr);
        tb_beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.empty = em; b.channel = ch; b.dir = dr; b.cyc = 0;
        return b;
    endfunction

    task automatic push_beat(input int unsigned p, input logic [63:0] d, input logic s, input logic e,
                             input logic [2:0] em, input logic [9:0] ch);
        src_q[p].push_back(mk(d, s, e, em, ch, p));
        mdl_q[p].push_back(mk(d, s, e, em, ch, p));
    endtask

    task automatic push_pkt(input int unsigned p, input int unsigned len, input logic [63:0] base);
        for (int j = 0; j < int'(len); j++)
            push_beat(p, base + 64'(j), j == 0, j == int'(len) - 1, 3'(p), 10'(p + 1));
    endtask

    // One clock: check holds, drive sources, record handshakes at the edge.
    task automatic cycle();
        bit [TX_DIR-1:0] acc;
        bit out_acc;
        tb_beat_t b;
        tb_beat_t ob;
        if (stalled) begin
            hold_cnt++;
            check("hold", out_vec(), held);
        end
        for (int i = 0; i < TX_DIR; i++) begin
            ast_valid_i[i] = 1'b0; ast_startofpacket_i[i] = 1'b0; ast_endofpacket_i[i] = 1'b0;
            ast_data_i[i] = '0; ast_empty_i[i] = '0; ast_channel_i[i] = '0;
            if (stray_mask[i]) begin
                ast_valid_i[i] = 1'b1;
                ast_data_i[i]  = STRAY;
            end else if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                ast_valid_i[i] = (b.sop || !gap_en) ? 1'b1 : ($urandom_range(0, 3) != 0);
                ast_startofpacket_i[i] = b.sop;
                ast_endofpacket_i[i]   = b.eop;
                ast_data_i[i]          = b.data;
                ast_empty_i[i]         = b.empty;
                ast_channel_i[i]       = b.channel;
            end
        end
        case (rdy_mode)
            1:       ast_ready_i = cyc[0];
            2:       ast_ready_i = ($urandom_range(0, 2) != 0);
            default: ast_ready_i = 1'b1;
        endcase
        #1;
        for (int i = 0; i < TX_DIR; i++)
            if (stray_mask[i]) check("stray_ready", 128'(ast_ready_o[i]), 128'(0));
        acc     = ast_valid_i & ast_ready_o;
        out_acc = ast_valid_o & ast_ready_i;
        stalled = ast_valid_o & ~ast_ready_i;
        held    = out_vec();
        ob = mk(ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o, 32'(dir_o));
        ob.cyc = cyc;
        @(posedge clk);
        for (int i = 0; i < TX_DIR; i++)
            if (acc[i] && !stray_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (out_acc) log_q.push_back(ob);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        cycle();
        srst_i = 1'b0;
        stalled = 1'b0;
        stray_mask = '0;
        for (int i = 0; i < TX_DIR; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
        end
        log_q.delete();
    endtask

    task automatic run_until(input int unsigned n, input int unsigned max_cyc);
        int unsigned k;
        k = 0;
        while (log_q.size() < n && k < max_cyc) begin
            cycle();
            k++;
        end
        check("beat_count", 128'(log_q.size()), 128'(n));
    endtask

    // Packet-level round-robin: next owner is the first port after the last
    // winner that still has packets queued; its whole packet follows.
    task automatic build_expected();
        int unsigned last;
        int unsigned p;
        int unsigned c;
        bit found;
        tb_beat_t b;
        last = TX_DIR - 1;
        exp_q.delete();
        for (int guard = 0; guard < 64; guard++) begin
            found = 1'b0;
            p = 0;
            for (int unsigned k = 1; k <= TX_DIR; k++) begin
                c = (last + k) % TX_DIR;
                if (!found && mdl_q[c].size() > 0) begin
                    found = 1'b1;
                    p = c;
                end
            end
            if (found) begin
                last = p;
                do begin
                    b = mdl_q[p].pop_front();
                    b.dir = p;
                    exp_q.push_back(b);
                end while (!b.eop && mdl_q[p].size() > 0);
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 4'b1110, 1};
        tbl[1] = '{1, 4'b1101, 2};
        tbl[2] = '{3, 4'b1111, 0};
        tbl[3] = '{2, 4'b1011, 3};
        tbl[4] = '{3, 4'b0110, 1};
        tbl[5] = '{1, 4'b0001, 0};
        tbl[6] = '{0, 4'b1001, 3};
        tbl[7] = '{2, 4'b0100, 2};

        @(negedge clk);
        do_reset();
        do_reset();
        check("rst_fields", out_vec(), 128'(0));
        check("rst_valid", 128'(ast_valid_o), 128'(0));
        check("rst_ready", 128'(ast_ready_o), 128'(0));

        // Arbitration table: last winner set by a lone packet, then a request mix.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            push_pkt(tbl[t].pre, 1, 64'hB00 + 64'(tbl[t].pre));
            run_until(1, 20);
            for (int p = 0; p < TX_DIR; p++)
                if (tbl[t].mask[p]) push_pkt(p, 1, 64'hA00 + 64'(p));
            run_until(2, 20);
            if (log_q.size() >= 2) begin
                check($sformatf("tbl%0d_dir", t), 128'(log_q[1].dir), 128'(tbl[t].exp_dir));
                check($sformatf("tbl%0d_data", t), 128'(log_q[1].data), 128'(64'hA00 + 64'(tbl[t].exp_dir)));
            end
        end

        // Single port, latency and field pass-through.
        begin
            int unsigned c0;
            tb_beat_t e[3];
            do_reset();
            c0 = cyc;
            push_beat(2, 64'h11, 1'b1, 1'b0, 3'd0, 10'd7);
            push_beat(2, 64'h22, 1'b0, 1'b0, 3'd0, 10'd7);
            push_beat(2, 64'h33, 1'b0, 1'b1, 3'd5, 10'd7);
            e[0] = mk(64'h11, 1'b1, 1'b0, 3'd0, 10'd7, 2);
            e[1] = mk(64'h22, 1'b0, 1'b0, 3'd0, 10'd7, 2);
            e[2] = mk(64'h33, 1'b0, 1'b1, 3'd5, 10'd7, 2);
            run_until(3, 20);
            for (int k = 0; k < 3 && k < int'(log_q.size()); k++) begin
                check($sformatf("single_beat%0d", k), beat_vec(log_q[k]), beat_vec(e[k]));
                check($sformatf("single_cyc%0d", k), 128'(log_q[k].cyc - c0), 128'(2 + k));
            end
        end

        // Contention: ports 0, 1, 3 with 2-beat packets, one bubble between packets.
        begin
            int unsigned c0;
            int unsigned dirs[6] = '{0, 0, 1, 1, 3, 3};
            int unsigned offs[6] = '{2, 3, 5, 6, 8, 9};
            do_reset();
            c0 = cyc;
            push_pkt(0, 2, 64'h000);
            push_pkt(1, 2, 64'h100);
            push_pkt(3, 2, 64'h300);
            run_until(6, 40);
            for (int k = 0; k < 6 && k < int'(log_q.size()); k++) begin
                check($sformatf("cont_dir%0d", k), 128'(log_q[k].dir), 128'(dirs[k]));
                check($sformatf("cont_data%0d", k), 128'(log_q[k].data), 128'(64'h100 * 64'(dirs[k]) + 64'(k % 2)));
                check($sformatf("cont_cyc%0d", k), 128'(log_q[k].cyc - c0), 128'(offs[k]));
            end
        end

        // Fairness: two ports with back-to-back single-beat packets alternate.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_pkt(0, 1, 64'h500 + 64'(k));
            push_pkt(1, 1, 64'h600 + 64'(k));
        end
        run_until(8, 60);
        for (int k = 0; k < 8 && k < int'(log_q.size()); k++)
            check($sformatf("fair_dir%0d", k), 128'(log_q[k].dir), 128'(k % 2));

        // Backpressure: toggling downstream ready; hold checks run every stall.
        begin
            int unsigned h0;
            do_reset();
            h0 = hold_cnt;
            rdy_mode = 1;
            push_pkt(1, 4, 64'h700);
            run_until(4, 40);
            rdy_mode = 0;
            for (int k = 0; k < 4 && k < int'(log_q.size()); k++)
                check($sformatf("bp_beat%0d", k), beat_vec(log_q[k]),
                      beat_vec(mk(64'h700 + 64'(k), k == 0, k == 3, 3'd1, 10'd2, 1)));
            check("bp_stalls_seen", 128'(hold_cnt > h0), 128'(1));
            repeat (3) cycle();
            check("bp_no_dup", 128'(log_q.size()), 128'(4));
        end

        // Reset in the middle of a 5-beat packet from port 3.
        do_reset();
        push_pkt(3, 5, 64'h800);
        run_until(2, 20);
        do_reset();
        check("mid_rst_valid", 128'(ast_valid_o), 128'(0));
        check("mid_rst_fields", out_vec(), 128'(0));
        push_pkt(3, 2, 64'h900);
        push_pkt(0, 2, 64'h980);
        run_until(4, 40);
        if (log_q.size() >= 4) begin
            check("mid_rst_first", beat_vec(log_q[0]), beat_vec(mk(64'h980, 1'b1, 1'b0, 3'd0, 10'd1, 0)));
            check("mid_rst_second_pkt", 128'(log_q[2].dir), 128'(3));
        end

        // Stray beat without sop on port 1 while port 0 owns the output.
        do_reset();
        stray_mask = 4'b0010;
        push_pkt(0, 4, 64'hC00);
        run_until(4, 30);
        repeat (3) cycle();
        check("stray_count", 128'(log_q.size()), 128'(4));
        for (int k = 0; k < 4 && k < int'(log_q.size()); k++)
            check($sformatf("stray_beat%0d", k), beat_vec(log_q[k]),
                  beat_vec(mk(64'hC00 + 64'(k), k == 0, k == 3, 3'd0, 10'd1, 0)));

        // Randomized traffic with valid gaps and random downstream ready.
        for (int r = 0; r < 6; r++) begin
            int unsigned np;
            int unsigned len;
            do_reset();
            gap_en = 1'b1;
            rdy_mode = 2;
            for (int p = 0; p < TX_DIR; p++) begin
                np = $urandom_range(0, 3);
                for (int k = 0; k < int'(np); k++) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < int'(len); j++)
                        push_beat(p, {$urandom, $urandom}, j == 0, j == int'(len) - 1,
                                  3'($urandom), 10'($urandom));
                end
            end
            build_expected();
            run_until(exp_q.size(), 40 * exp_q.size() + 50);
            for (int k = 0; k < int'(exp_q.size()) && k < int'(log_q.size()); k++)
                check($sformatf("rand%0d_beat%0d", r, k), beat_vec(log_q[k]), beat_vec(exp_q[k]));
            repeat (5) cycle();
            check($sformatf("rand%0d_total", r), 128'(log_q.size()), 128'(exp_q.size()));
            gap_en = 1'b0;
            rdy_mode = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
